multiword_serial_adder: RTL and testbench

- Sequential operand/result stage around a 4-bit slice adder.
- Accepts WIDTH-bit operands over a valid/ready handshake and adds them one 4-bit slice per cycle, LSB slice first.
- Carry between slices is kept in a register; the assembled sum is presented on an output valid/ready handshake.
- Gives arbitrary-width addition while reusing a 4-bit combinational adder core.

---
 rtl/multiword_serial_adder_pkg.sv | 18 +
 rtl/multiword_serial_adder_rca4.sv | 28 ++
 rtl/multiword_serial_adder.sv | 145 ++++++++++++++
 tb/tb_multiword_serial_adder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/multiword_serial_adder_pkg.sv
// Shared definitions for the multiword serial adder: slice width,
// FSM state encoding and the slice-count helper.
package multiword_serial_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of SLICE_W-bit slices needed to cover a word of the given width.
  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/multiword_serial_adder_rca4.sv
// Combinational 4-bit ripple adder slice. Besides the sum and carry out it
// exposes the carry into bit 3, which the top level needs for signed
// overflow detection on the most significant slice.
module rca4_slice
  import multiword_serial_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [4:0] full;
  logic [3:0] low3;

  // Full 4-bit add; the extra MSB is the carry out of bit 3.
  assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  // Add of the low three bits only; its MSB is the carry into bit 3.
  assign low3 = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};

  assign sum  = full[3:0];
  assign cout = full[4];
  assign c3   = low3[3];

endmodule

// File: rtl/multiword_serial_adder.sv
// Multiword serial adder: accepts WIDTH-bit operands on a valid/ready
// handshake, adds them one 4-bit slice per cycle (LSB slice first) through a
// single rca4_slice, and presents sum, carry out and signed overflow on an
// output valid/ready handshake.
module multiword_serial_adder
  import multiword_serial_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NSLICE = calc_nslice(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  // Reject widths the slice datapath cannot cover exactly.
  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("multiword_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end
  if (NSLICE != calc_nslice(WIDTH)) begin : g_nslice_check
    $error("multiword_serial_adder: NSLICE is derived from WIDTH and must not be overridden");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_c3;
  logic               accept;
  logic               release_out;
  logic               last_slice;

  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last_slice  = (cnt_r == CNT_LAST);

  // The counter selects which slice of the held operands feeds the adder.
  assign slice_a = a_r[SLICE_W*cnt_r +: SLICE_W];
  assign slice_b = b_r[SLICE_W*cnt_r +: SLICE_W];

  rca4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_r),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // FSM state register; reset aborts any addition in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> ADD on accept, ADD -> DONE after the last slice,
  // DONE -> IDLE once the consumer takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = ADD;
      ADD:     if (last_slice)  state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend only on the state, so inputs never pass through.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, per-slice accumulation and final flag capture. The sum
  // register is written in place, so it holds the last result while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= in_a;
            b_r     <= in_b;
            carry_r <= in_cin;
            cnt_r   <= '0;
          end
        end
        ADD: begin
          sum_r[SLICE_W*cnt_r +: SLICE_W] <= slice_sum;
          carry_r                         <= slice_cout;
          cnt_r                           <= cnt_r + 1'b1;
          if (last_slice) begin
            cout_r <= slice_cout;
            ovf_r  <= slice_c3 ^ slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_r;
  assign out_cout = cout_r;
  assign out_ovf  = ovf_r;

endmodule

// File: tb/tb_multiword_serial_adder.sv
// Directed bench for multiword_serial_adder at WIDTH=16.
module tb_multiword_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int checks;
  int failures;

  multiword_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one word, follow it through ADD into DONE, verify latency,
  // result and flags, then complete the output handshake.
  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
    int lat;
    @(negedge clk);
    check({tag, "_rdy_before"}, in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      check({tag, "_rdy_busy"}, in_ready, 0);
      if (out_valid) lat = k;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_cout"}, out_cout, exp_cout);
    check({tag, "_ovf"}, out_ovf, exp_ovf);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_after"}, out_valid, 0);
    check({tag, "_rdy_after"}, in_ready, 1);
    check({tag, "_sum_hold"}, out_sum, exp_sum);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_ovf", out_ovf, 0);
    #11 rst_n = 1'b1;

    run_add("basic",   16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_add("cross",   16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0);
    run_add("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("negovf",  16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    run_add("ripple",  16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: result must hold while in_valid stays asserted.
    @(negedge clk);
    in_a = 16'h1234; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_a = 16'hDEAD; in_b = 16'hBEEF;
    for (int k = 1; k <= 20 && !out_valid; k++) @(negedge clk);
    check("bp_reach_done", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 16'h2345);
      check("bp_cout", out_cout, 0);
      check("bp_ovf", out_ovf, 0);
      check("bp_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_rdy_after", in_ready, 1);

    // Accept a word whose result would set cout, then reset during ADD.
    @(negedge clk);
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_add", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_sum", out_sum, 0);
    check("abort_cout", out_cout, 0);
    check("abort_ovf", out_ovf, 0);
    check("abort_rdy", in_ready, 1);
    #6 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_abort_valid", out_valid, 0);
      check("post_abort_rdy", in_ready, 1);
    end

    // Normal operation resumes after the abort.
    run_add("resume",  16'h1000, 16'h0FFF, 1'b1, 16'h2000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
